// File: rtl/ita_step_sequencer_pkg.sv
// Shared types and step-sequencing helpers for the ITA step sequencer.
// Optional busy-cycle counter in the top is enabled by defining ITA_SEQ_PERF_EN.
package ita_step_sequencer_pkg;

  typedef logic [31:0] tile_t;

  typedef enum logic [3:0] {
    Idle, Q, K, V, QK, AV, OW, F1, F2, MatMul
  } step_e;

  typedef enum logic [1:0] {Attention, Feedforward, Linear, SingleAttention} layer_e;

  typedef enum logic [1:0] {Identity, Gelu, Relu} activation_e;

  typedef struct packed {
    layer_e      layer;
    activation_e activation;
    tile_t       tile_s;
    tile_t       tile_e;
    tile_t       tile_p;
    tile_t       tile_f;
  } ita_seq_cfg_t;

  typedef struct packed {
    logic         start;
    ita_seq_cfg_t cfg;
  } ctrl_t;

  typedef struct packed {
    tile_t outer;
    tile_t mid;
    tile_t inner;
  } ita_seq_limits_t;

  function automatic tile_t tile_nz(tile_t t);
    return (t == '0) ? tile_t'(1) : t;
  endfunction

  function automatic logic [2:0] step_requant_idx(step_e s);
    case (s)
      K:       return 3'd1;
      V:       return 3'd2;
      QK:      return 3'd3;
      AV:      return 3'd4;
      OW:      return 3'd5;
      F1:      return 3'd6;
      F2:      return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic step_e layer_first_step(layer_e l);
    case (l)
      Attention:   return Q;
      Feedforward: return F1;
      Linear:      return MatMul;
      default:     return QK;
    endcase
  endfunction

  // Idle marks the end of the layer.
  function automatic step_e layer_next_step(layer_e l, step_e s);
    case (s)
      Q:       return K;
      K:       return V;
      V:       return QK;
      QK:      return AV;
      AV:      return (l == Attention) ? OW : Idle;
      F1:      return F2;
      default: return Idle;
    endcase
  endfunction

  function automatic ita_seq_limits_t step_limits(step_e s, tile_t ts, tile_t te, tile_t tp,
                                                  tile_t tf);
    ita_seq_limits_t lim;
    tile_t s_nz, e_nz, p_nz, f_nz;
    s_nz = tile_nz(ts);
    e_nz = tile_nz(te);
    p_nz = tile_nz(tp);
    f_nz = tile_nz(tf);
    lim = '{outer: tile_t'(1), mid: tile_t'(1), inner: tile_t'(1)};
    case (s)
      Q, K, V, MatMul: lim = '{outer: s_nz, mid: p_nz, inner: e_nz};
      QK:              lim = '{outer: s_nz, mid: s_nz, inner: p_nz};
      AV:              lim = '{outer: s_nz, mid: p_nz, inner: s_nz};
      OW:              lim = '{outer: s_nz, mid: e_nz, inner: p_nz};
      F1:              lim = '{outer: s_nz, mid: f_nz, inner: e_nz};
      F2:              lim = '{outer: s_nz, mid: e_nz, inner: f_nz};
      default:         ;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/ita_step_sequencer_if.sv
// Control/datapath-facing bundle of the ITA step sequencer.
interface ita_step_sequencer_if
  import ita_step_sequencer_pkg::*;
#(
  parameter int unsigned CntWidth = 32
);
  ctrl_t                ctrl;
  logic                 tile_done;
  step_e                step;
  logic                 busy;
  logic                 done;
  logic [2:0]           requant_idx;
  logic                 act_en;
  logic                 inner_first;
  logic                 inner_last;
  logic                 step_last_tile;
  logic [CntWidth-1:0]  outer_cnt;
  logic [CntWidth-1:0]  mid_cnt;
  logic [CntWidth-1:0]  inner_cnt;
  logic [31:0]          busy_cycles;

  modport master (
    output ctrl, tile_done,
    input  step, busy, done, requant_idx, act_en, inner_first, inner_last, step_last_tile,
    input  outer_cnt, mid_cnt, inner_cnt, busy_cycles
  );

  modport slave (
    input  ctrl, tile_done,
    output step, busy, done, requant_idx, act_en, inner_first, inner_last, step_last_tile,
    output outer_cnt, mid_cnt, inner_cnt, busy_cycles
  );
endinterface

// File: rtl/ita_tile_counter.sv
// Three cascaded tile counters (outer/mid/inner) with per-level limits.
// The whole nest returns to zero on clear or on advancing past the last tile.
module ita_tile_counter #(
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                advance_i,
  input  logic [CntWidth-1:0] outer_lim_i,
  input  logic [CntWidth-1:0] mid_lim_i,
  input  logic [CntWidth-1:0] inner_lim_i,
  output logic [CntWidth-1:0] outer_o,
  output logic [CntWidth-1:0] mid_o,
  output logic [CntWidth-1:0] inner_o,
  output logic                inner_first_o,
  output logic                inner_last_o,
  output logic                last_o
);
  logic [CntWidth-1:0] outer_q, outer_d, mid_q, mid_d, inner_q, inner_d;
  logic                mid_last, outer_last;

  assign inner_last_o  = inner_q == (inner_lim_i - CntWidth'(1));
  assign mid_last      = mid_q == (mid_lim_i - CntWidth'(1));
  assign outer_last    = outer_q == (outer_lim_i - CntWidth'(1));
  assign last_o        = inner_last_o && mid_last && outer_last;
  assign inner_first_o = inner_q == '0;

  always_comb begin
    outer_d = outer_q;
    mid_d   = mid_q;
    inner_d = inner_q;
    if (clear_i || (advance_i && last_o)) begin
      outer_d = '0;
      mid_d   = '0;
      inner_d = '0;
    end else if (advance_i) begin
      if (inner_last_o) begin
        inner_d = '0;
        if (mid_last) begin
          mid_d   = '0;
          outer_d = outer_q + CntWidth'(1);
        end else begin
          mid_d = mid_q + CntWidth'(1);
        end
      end else begin
        inner_d = inner_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outer_q <= '0;
      mid_q   <= '0;
      inner_q <= '0;
    end else begin
      outer_q <= outer_d;
      mid_q   <= mid_d;
      inner_q <= inner_d;
    end
  end

  assign outer_o = outer_q;
  assign mid_o   = mid_q;
  assign inner_o = inner_q;
endmodule

// File: rtl/ita_step_sequencer.sv
// Walks one ITA layer invocation through its steps and nested tile loops.
// Define ITA_SEQ_PERF_EN to build the saturating busy-cycle counter.
module ita_step_sequencer
  import ita_step_sequencer_pkg::*;
#(
  parameter int unsigned CntWidth = 32,
  parameter int unsigned NumSteps = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  ita_step_sequencer_if.slave  seq_if
);
  step_e           step_q, step_d;
  ita_seq_cfg_t    cfg_q, cfg_d;
  logic            done_q, done_d;
  logic            busy, advance, start_ok, tile_last, inner_first, inner_last;
  ita_seq_limits_t lim;

  assign busy = step_q != Idle;
  assign lim  = step_limits(step_q, cfg_q.tile_s, cfg_q.tile_e, cfg_q.tile_p, cfg_q.tile_f);

  always_comb begin
    step_d   = step_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    advance  = 1'b0;
    start_ok = 1'b0;
    if (clear_i) begin
      step_d = Idle;
    end else if (!busy) begin
      if (seq_if.ctrl.start) begin
        start_ok = 1'b1;
        cfg_d    = seq_if.ctrl.cfg;
        step_d   = layer_first_step(seq_if.ctrl.cfg.layer);
      end
    end else if (int'(step_q) >= int'(NumSteps)) begin
      step_d = Idle;  // recover from an unused encoding
    end else if (seq_if.tile_done) begin
      advance = 1'b1;
      if (tile_last) begin
        step_d = layer_next_step(cfg_q.layer, step_q);
        done_d = step_d == Idle;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_q <= Idle;
      cfg_q  <= '0;
      done_q <= 1'b0;
    end else begin
      step_q <= step_d;
      cfg_q  <= cfg_d;
      done_q <= done_d;
    end
  end

  ita_tile_counter #(
    .CntWidth(CntWidth)
  ) u_tile_counter (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .advance_i     (advance),
    .outer_lim_i   (CntWidth'(lim.outer)),
    .mid_lim_i     (CntWidth'(lim.mid)),
    .inner_lim_i   (CntWidth'(lim.inner)),
    .outer_o       (seq_if.outer_cnt),
    .mid_o         (seq_if.mid_cnt),
    .inner_o       (seq_if.inner_cnt),
    .inner_first_o (inner_first),
    .inner_last_o  (inner_last),
    .last_o        (tile_last)
  );

  assign seq_if.step           = step_q;
  assign seq_if.busy           = busy;
  assign seq_if.done           = done_q;
  assign seq_if.requant_idx    = step_requant_idx(step_q);
  assign seq_if.act_en         = (step_q == F1 || step_q == MatMul) && cfg_q.activation != Identity;
  assign seq_if.inner_first    = busy && inner_first;
  assign seq_if.inner_last     = busy && inner_last;
  assign seq_if.step_last_tile = busy && tile_last;

`ifdef ITA_SEQ_PERF_EN
  logic [31:0] busy_cycles_q, busy_cycles_d;

  always_comb begin
    busy_cycles_d = busy_cycles_q;
    if (start_ok) begin
      busy_cycles_d = '0;
    end else if (busy && busy_cycles_q != '1) begin
      busy_cycles_d = busy_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_cycles_q <= '0;
    end else begin
      busy_cycles_q <= busy_cycles_d;
    end
  end

  assign seq_if.busy_cycles = busy_cycles_q;
`else
  assign seq_if.busy_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_ita_step_sequencer.sv
// Self-checking bench for ita_step_sequencer: tile-index reference model plus directed scenarios.
module tb_ita_step_sequencer;
  import ita_step_sequencer_pkg::*;

  localparam int unsigned CntWidth = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  bit   cmp_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ita_step_sequencer_if #(.CntWidth(CntWidth)) sif ();

  ita_step_sequencer #(
    .CntWidth(CntWidth),
    .NumSteps(10)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(clear),
    .seq_if (sif)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: step list + linear tile index ----------------
  step_e       m_seq[$];
  int unsigned m_idx, m_t, m_perf;
  bit          m_busy, m_done;
  int unsigned ms, me, mp, mf;
  activation_e m_act;

  function automatic int unsigned nz(input tile_t v);
    return (v == 0) ? 1 : int'(v);
  endfunction

  function automatic void dims(input step_e s, output int unsigned lo, lm, li);
    lo = ms;
    case (s)
      QK:      begin lm = ms; li = mp; end
      AV:      begin lm = mp; li = ms; end
      OW:      begin lm = me; li = mp; end
      F1:      begin lm = mf; li = me; end
      F2:      begin lm = me; li = mf; end
      default: begin lm = mp; li = me; end
    endcase
  endfunction

  function automatic int unsigned exp_rq(input step_e s);
    case (s)
      K: return 1;  V: return 2;  QK: return 3; AV: return 4;
      OW: return 5; F1: return 6; F2: return 7; default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_upd
    bit          was_busy;
    int unsigned lo, lm, li;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_idx = 0; m_t = 0; m_perf = 0;
      m_seq.delete();
    end else begin
      was_busy = m_busy;
      m_done   = 1'b0;
      if (was_busy && m_perf != 32'hFFFF_FFFF) m_perf++;
      if (clear) begin
        m_busy = 1'b0; m_t = 0;
      end else if (!was_busy) begin
        if (sif.ctrl.start) begin
          ms = nz(sif.ctrl.cfg.tile_s); me = nz(sif.ctrl.cfg.tile_e);
          mp = nz(sif.ctrl.cfg.tile_p); mf = nz(sif.ctrl.cfg.tile_f);
          m_act = sif.ctrl.cfg.activation;
          m_seq.delete();
          case (sif.ctrl.cfg.layer)
            Attention:   begin m_seq.push_back(Q); m_seq.push_back(K); m_seq.push_back(V);
                               m_seq.push_back(QK); m_seq.push_back(AV); m_seq.push_back(OW); end
            Feedforward: begin m_seq.push_back(F1); m_seq.push_back(F2); end
            Linear:      m_seq.push_back(MatMul);
            default:     begin m_seq.push_back(QK); m_seq.push_back(AV); end
          endcase
          m_idx = 0; m_t = 0; m_busy = 1'b1; m_perf = 0;
        end
      end else if (sif.tile_done) begin
        dims(m_seq[m_idx], lo, lm, li);
        m_t++;
        if (m_t == lo * lm * li) begin
          m_t = 0;
          m_idx++;
          if (m_idx == m_seq.size()) begin
            m_busy = 1'b0; m_done = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    step_e       es;
    int unsigned lo, lm, li, ii, mi, oi, tot;
    if (rst_n && cmp_en) begin
      es = Idle; ii = 0; mi = 0; oi = 0; li = 1; tot = 1;
      if (m_busy) begin
        es = m_seq[m_idx];
        dims(es, lo, lm, li);
        tot = lo * lm * li;
        ii  = m_t % li;
        mi  = (m_t / li) % lm;
        oi  = m_t / (li * lm);
      end
      check("step", sif.step, es);
      check("busy", sif.busy, m_busy);
      check("done", sif.done, m_done);
      check("requant_idx", sif.requant_idx, exp_rq(es));
      check("act_en", sif.act_en, m_busy && (es == F1 || es == MatMul) && m_act != Identity);
      check("inner_cnt", sif.inner_cnt, ii);
      check("mid_cnt", sif.mid_cnt, mi);
      check("outer_cnt", sif.outer_cnt, oi);
      check("inner_first", sif.inner_first, m_busy && ii == 0);
      check("inner_last", sif.inner_last, m_busy && ii == li - 1);
      check("step_last_tile", sif.step_last_tile, m_busy && m_t == tot - 1);
`ifdef ITA_SEQ_PERF_EN
      check("busy_cycles", sif.busy_cycles, m_perf);
`else
      check("busy_cycles", sif.busy_cycles, 0);
`endif
    end
  end

  // ---------------- observation statistics for literal expectations ----------------
  int    tiles_acc, done_cnt;
  int    tiles_in[10], ilast_in[10], act_in[10];
  int    rq_seq[$];
  step_e prev_step = Idle;

  always @(posedge clk) begin
    if (rst_n && sif.busy && sif.tile_done && !clear) begin
      tiles_acc++;
      tiles_in[int'(sif.step)]++;
      if (sif.inner_last) ilast_in[int'(sif.step)]++;
      if (sif.act_en) act_in[int'(sif.step)]++;
    end
  end

  always @(negedge clk) begin
    if (sif.done) done_cnt++;
    if (sif.busy && sif.step != prev_step) rq_seq.push_back(int'(sif.requant_idx));
    prev_step = sif.step;
  end

  task automatic clear_stats();
    tiles_acc = 0; done_cnt = 0; rq_seq.delete();
    for (int i = 0; i < 10; i++) begin
      tiles_in[i] = 0; ilast_in[i] = 0; act_in[i] = 0;
    end
  endtask

  task automatic start_layer(input layer_e l, input activation_e a, input tile_t ts, te, tp, tf);
    @(negedge clk);
    sif.ctrl.cfg   = '{layer: l, activation: a, tile_s: ts, tile_e: te, tile_p: tp, tile_f: tf};
    sif.ctrl.start = 1'b1;
    @(negedge clk);
    sif.ctrl.start = 1'b0;
  endtask

  task automatic run_to_done(input int unsigned pct, input int budget, input string name);
    int n = 0;
    while (!sif.done && n < budget) begin
      sif.tile_done = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      n++;
    end
    sif.tile_done = 1'b0;
    check(name, sif.done, 1);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    sif.tile_done = 1'b0;
    #1;
    check("arst_step", sif.step, Idle);
    check("arst_busy", sif.busy, 0);
    check("arst_cnt", {sif.outer_cnt, sif.mid_cnt} | 64'(sif.inner_cnt), 0);
    check("arst_first", sif.inner_first, 0);
    check("arst_perf", sif.busy_cycles, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    layer_e      rl;
    activation_e ra;
    int unsigned pct, mode, k, n;

    rst_n = 1'b0; clear = 1'b0; sif.ctrl = '0; sif.tile_done = 1'b0;
    clear_stats();
    repeat (2) @(negedge clk);
    check("rst_step", sif.step, Idle);
    check("rst_busy", sif.busy, 0);
    check("rst_done", sif.done, 0);
    check("rst_flags", {sif.act_en, sif.inner_first, sif.inner_last, sif.step_last_tile}, 0);
    check("rst_rq", sif.requant_idx, 0);
    check("rst_perf", sif.busy_cycles, 0);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Attention s=2 e=1 p=1, one tile per cycle
    clear_stats();
    start_layer(Attention, Identity, 2, 1, 1, 0);
    run_to_done(100, 200, "att_timeout");
    @(negedge clk);
    check("att_tiles", tiles_acc, 16);
    check("att_done_cnt", done_cnt, 1);
    check("att_idle", sif.step, Idle);
    check("att_q", tiles_in[int'(Q)], 2);
    check("att_k", tiles_in[int'(K)], 2);
    check("att_v", tiles_in[int'(V)], 2);
    check("att_qk", tiles_in[int'(QK)], 4);
    check("att_av", tiles_in[int'(AV)], 4);
    check("att_ow", tiles_in[int'(OW)], 2);
    check("att_rq_n", rq_seq.size(), 6);
    for (int i = 0; i < rq_seq.size(); i++) check($sformatf("att_rq%0d", i), rq_seq[i], i);

    // Feedforward s=1 e=2 f=3 Gelu
    clear_stats();
    start_layer(Feedforward, Gelu, 1, 2, 0, 3);
    run_to_done(100, 200, "ff_timeout");
    check("ff_f1", tiles_in[int'(F1)], 6);
    check("ff_f2", tiles_in[int'(F2)], 6);
    check("ff_act_f1", act_in[int'(F1)], 6);
    check("ff_act_f2", act_in[int'(F2)], 0);
    check("ff_ilast_f1", ilast_in[int'(F1)], 3);
    check("ff_ilast_f2", ilast_in[int'(F2)], 2);
    check("ff_rq_n", rq_seq.size(), 2);
    if (rq_seq.size() == 2) check("ff_rq_f2", rq_seq[1], 7);

    // Linear, all tiles zero -> single tile
    start_layer(Linear, Relu, 0, 0, 0, 0);
    check("lin_step", sif.step, MatMul);
    check("lin_flags", {sif.inner_first, sif.inner_last, sif.step_last_tile}, 3'b111);
    sif.tile_done = 1'b1;
    @(negedge clk);
    sif.tile_done = 1'b0;
    check("lin_done", sif.done, 1);
    check("lin_idle", sif.step, Idle);

    // spurious tile_done in Idle, then start with tile_done together
    @(negedge clk);
    clear_stats();
    sif.tile_done = 1'b1;
    repeat (3) @(negedge clk);
    sif.ctrl.cfg   = '{layer: Attention, activation: Identity, tile_s: 1, tile_e: 1, tile_p: 1,
                       tile_f: 0};
    sif.ctrl.start = 1'b1;
    @(negedge clk);
    sif.ctrl.start = 1'b0;
    sif.tile_done  = 1'b0;
    check("spur_step", sif.step, Q);
    check("spur_cnt", {sif.outer_cnt, sif.mid_cnt} | 64'(sif.inner_cnt), 0);
    check("spur_tiles", tiles_acc, 0);
    check("spur_done", done_cnt, 0);
    run_to_done(100, 100, "spur_timeout");

    // clear during AV with start also high
    start_layer(Attention, Identity, 2, 1, 1, 0);
    clear_stats();
    n = 0;
    while (sif.step != AV && n < 50) begin
      sif.tile_done = 1'b1;
      @(negedge clk);
      n++;
    end
    check("clr_reach_av", sif.step, AV);
    sif.tile_done  = 1'b0;
    clear          = 1'b1;
    sif.ctrl.start = 1'b1;
    @(negedge clk);
    clear          = 1'b0;
    sif.ctrl.start = 1'b0;
    check("clr_idle", sif.step, Idle);
    check("clr_cnt", {sif.outer_cnt, sif.mid_cnt} | 64'(sif.inner_cnt), 0);
    @(negedge clk);
    check("clr_start_dropped", sif.step, Idle);
    check("clr_no_done", done_cnt, 0);

    // busy-cycle counter: Linear 1/1/1, tile_done after 5 busy cycles
    start_layer(Linear, Identity, 1, 1, 1, 0);
    repeat (4) @(negedge clk);
    sif.tile_done = 1'b1;
    @(negedge clk);
    sif.tile_done = 1'b0;
    check("perf_done", sif.done, 1);
`ifdef ITA_SEQ_PERF_EN
    check("perf_at_done", sif.busy_cycles, 5);
    repeat (3) @(negedge clk);
    check("perf_hold", sif.busy_cycles, 5);
`else
    check("perf_at_done", sif.busy_cycles, 0);
    repeat (3) @(negedge clk);
    check("perf_hold", sif.busy_cycles, 0);
`endif
    start_layer(Linear, Identity, 1, 1, 1, 0);
    check("perf_restart", sif.busy_cycles, 0);
    run_to_done(100, 50, "perf_timeout");

    // randomized layers, occasional clear or async reset mid-run
    for (int it = 0; it < 30; it++) begin
      rl   = layer_e'($urandom_range(0, 3));
      ra   = activation_e'($urandom_range(0, 2));
      pct  = $urandom_range(30, 100);
      mode = $urandom_range(0, 7);
      start_layer(rl, ra, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3));
      if (mode <= 1) begin
        k = $urandom_range(1, 20);
        for (int c = 0; c < k && !sif.done; c++) begin
          sif.tile_done = ($urandom_range(0, 99) < pct);
          @(negedge clk);
        end
        sif.tile_done = 1'b0;
        if (mode == 0) begin
          clear = 1'b1;
          @(negedge clk);
          clear = 1'b0;
          check("rnd_clear_idle", sif.step, Idle);
        end else begin
          async_reset();
        end
      end else begin
        run_to_done(pct, 3000, "rnd_timeout");
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ita_step_sequencer.md
Name: ita_step_sequencer

Overview:
- Sequences the ITA datapath through the steps of one layer invocation: Idle, Q, K, V, QK, AV, OW, F1, F2, MatMul.
- Latches the control word on start and runs nested tile counters (outer/mid/inner) per step.
- Drives step, requant-constant index, activation enable and first/last-inner-tile flags to the accumulator, requantizer and activation blocks.
- Sits between the ctrl_t register file and the datapath; advances on the datapath's per-tile completion pulse.

Parameters:
- CntWidth, 32, width of tile counters and tile limits (matches tile_t).
- NumSteps, 10, number of step_e encodings.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft abort; returns to Idle
- ctrl_i  in  ctrl_t  layer, activation, tile_s/e/p/f, start
- tile_done_i  in  1  datapath finished current tile (1-cycle pulse)
- step_o  out  step_e  current step
- busy_o  out  1  step_o != Idle
- done_o  out  1  1-cycle pulse when layer completes
- requant_idx_o  out  3  index into eps_mult/right_shift/add arrays
- act_en_o  out  1  apply ctrl activation on this step
- inner_first_o  out  1  inner counter == 0 (clear accumulator/load bias)
- inner_last_o  out  1  inner counter == limit-1 (emit/requantize output)
- step_last_tile_o  out  1  current tile is the last of the step
- outer_cnt_o, mid_cnt_o, inner_cnt_o  out  CntWidth each  tile coordinates
- busy_cycles_o  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset (async, rst_ni low) values:
  - step_o = Idle; all counters 0.
  - busy_o, done_o, act_en_o, step_last_tile_o = 0; requant_idx_o = 0; busy_cycles_o = 0.
  - inner_first_o = 0 (flags are gated by busy_o).
- Start:
  - ctrl_i.start high in Idle latches ctrl_i.
  - step_o takes the first step of the layer on the next edge; counters are 0.
  - start is ignored while busy.
- Step sequence by layer:
  - Attention: Q, K, V, QK, AV, OW
  - Feedforward: F1, F2
  - Linear: MatMul
  - SingleAttention: QK, AV
- Loop limits (outer, mid, inner) per step:
  - Q/K/V: (s, p, e)
  - QK: (s, s, p)
  - AV: (s, p, s)
  - OW: (s, e, p)
  - F1: (s, f, e)
  - F2: (s, e, f)
  - MatMul: (s, p, e)
  - A latched tile value of 0 is treated as 1.
- Counter advance, on tile_done_i while busy:
  - inner increments.
  - At inner limit-1, inner wraps to 0 and mid increments.
  - At mid limit-1, mid wraps to 0 and outer increments.
  - tile_done_i with step_last_tile_o = 1 moves to the next step next cycle with all counters 0.
  - After the final step, the sequencer enters Idle and done_o pulses for that one cycle.
- step_last_tile_o = all three counters at limit-1 (combinational from registers).
- requant_idx_o:
  - Q=0, K=1, V=2, QK=3, AV=4, OW=5, F1=6, F2=7, MatMul=0, Idle=0.
- act_en_o = 1 only in F1 and MatMul, and only when the latched activation != Identity.
- tile_done_i in Idle is ignored; it never produces a done_o.
- Start with tile_done_i in the same Idle cycle: start is taken, tile_done_i is ignored.
- clear_i has priority over everything:
  - next cycle: Idle, counters 0, done_o = 0.
  - A start arriving together with clear_i is dropped.
- Mid-operation async reset returns all state to reset values immediately.
- No wrap of the 32-bit counters is possible because each counter is bounded by its limit.

Optional Feature:
- Macro ITA_SEQ_PERF_EN.
- Defined:
  - busy_cycles_o counts clock cycles with busy_o = 1.
  - It is cleared to 0 on an accepted start and holds its value in Idle after done_o.
  - It saturates at 2^32-1.
- Undefined: busy_cycles_o is tied to 0 and no counter register is synthesized.

Decomposition:
- Shared package (extends the ITA package):
  - ita_seq_limits_t struct {outer, mid, inner : tile_t}
  - step-to-requant-index mapping function
  - per-layer first-step and next-step functions
- One sub-module, ita_tile_counter: three nested cascaded counters with limits, an advance input and first/last flags; instantiated once.

Test Plan:
- Attention, tile_s=2, tile_e=1, tile_p=1, one tile_done_i per cycle:
  - Q, K, V each last 2 tiles; QK, AV last 4 tiles; OW lasts 2 tiles.
  - done_o pulses once, 16 tile_done_i after start, then step_o = Idle.
  - requant_idx_o reads 0..5 in order.
- Feedforward, tile_s=1, tile_e=2, tile_f=3, activation=Gelu:
  - F1 lasts 6 tiles with act_en_o = 1; F2 lasts 6 tiles with act_en_o = 0 and requant_idx_o = 7.
  - inner_last_o high on every 2nd tile in F1 and every 3rd tile in F2.
- Linear, all tiles 0:
  - Exactly one MatMul tile; inner_first_o = inner_last_o = step_last_tile_o = 1.
  - done_o follows the single tile_done_i.
- Spurious tile_done_i pulses in Idle, then start with tile_done_i in the same cycle:
  - No done_o.
  - step_o = Q next cycle with all counters 0.
- clear_i asserted during AV with start also high:
  - Idle next cycle, counters 0, no done_o.
  - The start is dropped.
- Perf, ITA_SEQ_PERF_EN defined, Linear with tile_s=tile_p=tile_e=1, tile_done_i 5 cycles after start:
  - busy_cycles_o = 5 at done_o.
  - busy_cycles_o holds 5 afterwards and resets to 0 on the next start.
